// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I core.
// Holds the opcode constants the controller decodes, the control FSM state encoding,
// and the datapath mux-select / ALU-op encodings shared by the controller and datapath.
package riscv_pkg;

    // Opcodes (instruction[6:0]) the controller supports
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Control FSM state encoding; values 11..15 are unreachable
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWRITE = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    // ALU operand A select
    localparam logic [1:0] ALU_A_PC    = 2'b00;
    localparam logic [1:0] ALU_A_OLDPC = 2'b01;
    localparam logic [1:0] ALU_A_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] ALU_B_RS2  = 2'b00;
    localparam logic [1:0] ALU_B_IMM  = 2'b01;
    localparam logic [1:0] ALU_B_FOUR = 2'b10;

    // ALU operation class handed to the ALU-control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Result (writeback / PC source) select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // True for the two opcodes that go through the address-calculation state
    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main control state machine of the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback one step per clock from the
// latched opcode, driving the datapath mux selects and write enables (Moore style).
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   opcode[6:0]     instruction[6:0] from the instruction register
//   zero            ALU zero flag, used for beq
//   mem_ready       memory access completes this cycle
//   ir_write        load instruction register
//   pc_write        pc_update | (branch & zero)
//   adr_src         memory address: 0 PC, 1 ALU out register
//   mem_write       data memory write enable
//   reg_write       register file write enable
//   alu_src_a[1:0]  ALU A select, alu_src_b[1:0] ALU B select
//   alu_op[1:0]     ALU operation class, result_src[1:0] result mux select
//   illegal_instr   one-cycle pulse in DECODE for an unsupported opcode
//   state_dbg[3:0]  current state encoding
//
// Handshake: mem_ready is a per-cycle completion strobe. In FETCH, MEMREAD and
// MEMWRITE the request is held (outputs unchanged) every cycle mem_ready is 0; the
// cycle mem_ready is 1 is the completing cycle and the FSM advances at its end.
// With WAIT_ON_MEM=0 mem_ready is ignored and treated as always 1.
module multicycle_control_fsm
    import riscv_pkg::*;
#(
    parameter bit WAIT_ON_MEM = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       mem_done;

    logic       ir_write_c;
    logic       pc_update_c;
    logic       branch_c;
    logic       mem_write_c;
    logic       reg_write_c;

    assign mem_done = WAIT_ON_MEM ? mem_ready : 1'b1;

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_mem_op(opcode))         state_d = S_MEMADR;
                else if (opcode == OP_RTYPE)   state_d = S_EXECUTER;
                else if (opcode == OP_ITYPE)   state_d = S_EXECUTEI;
                else if (opcode == OP_JAL)     state_d = S_JAL;
                else if (opcode == OP_BRANCH)  state_d = S_BEQ;
                else                           state_d = S_FETCH;
            end
            S_MEMADR: begin
                if (opcode == OP_LOAD)         state_d = S_MEMREAD;
                else if (opcode == OP_STORE)   state_d = S_MEMWRITE;
                else                           state_d = S_FETCH;
            end
            S_MEMREAD:  state_d = mem_done ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_done ? S_FETCH : S_MEMWRITE;
            S_MEMWB:    state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // ---------------------------------------------------------------
    // Output decode (Moore, plus the mem_ready / zero qualifiers)
    // ---------------------------------------------------------------
    always_comb begin
        ir_write_c    = 1'b0;
        pc_update_c   = 1'b0;
        branch_c      = 1'b0;
        mem_write_c   = 1'b0;
        reg_write_c   = 1'b0;
        adr_src       = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        result_src    = 2'b00;
        illegal_instr = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC+4 computed on the direct ALU result and written as the fetch completes
                alu_src_a   = ALU_A_PC;
                alu_src_b   = ALU_B_FOUR;
                alu_op      = ALUOP_ADD;
                result_src  = RES_ALURESULT;
                ir_write_c  = mem_done;
                pc_update_c = mem_done;
            end
            S_DECODE: begin
                // Speculative branch target (old PC + imm) lands in the ALU out register
                alu_src_a = ALU_A_OLDPC;
                alu_src_b = ALU_B_IMM;
                alu_op    = ALUOP_ADD;
                illegal_instr = !(is_mem_op(opcode) || opcode == OP_RTYPE ||
                                  opcode == OP_ITYPE || opcode == OP_JAL ||
                                  opcode == OP_BRANCH);
            end
            S_MEMADR: begin
                alu_src_a = ALU_A_RS1;
                alu_src_b = ALU_B_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                result_src  = RES_ALUOUT;
                mem_write_c = 1'b1;
            end
            S_MEMWB: begin
                result_src  = RES_MEMDATA;
                reg_write_c = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = ALU_A_RS1;
                alu_src_b = ALU_B_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = ALU_A_RS1;
                alu_src_b = ALU_B_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                result_src  = RES_ALUOUT;
                reg_write_c = 1'b1;
            end
            S_JAL: begin
                // Jump target (from DECODE) goes to PC while ALU computes old PC + 4 for rd
                alu_src_a   = ALU_A_OLDPC;
                alu_src_b   = ALU_B_FOUR;
                alu_op      = ALUOP_ADD;
                result_src  = RES_ALUOUT;
                pc_update_c = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = ALU_A_RS1;
                alu_src_b  = ALU_B_RS2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                branch_c   = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are gated by rst directly so nothing is written while reset
    // is held, even though the FETCH selects are already presented.
    assign ir_write  = ir_write_c & ~rst;
    assign pc_write  = (pc_update_c | (branch_c & zero)) & ~rst;
    assign mem_write = mem_write_c & ~rst;
    assign reg_write = reg_write_c & ~rst;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: random instruction stream with
// random memory wait states, a step-list reference model, and a scoreboard monitor.
module tb_multicycle_control_fsm;
  import riscv_pkg::*;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       ir_write, pc_write, adr_src, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       illegal_instr;
  logic [3:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_control_fsm #(.WAIT_ON_MEM(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .illegal_instr(illegal_instr), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Instruction kinds and the step names each one walks through
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_BEQ = 5, K_ILL = 6;
  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MW = 4, P_MWB = 5,
                 P_ER = 6, P_EI = 7, P_AWB = 8, P_J = 9, P_B = 10;

  // Expected output vector {state, ir, pc, adr, mw, rw, a, b, op, res, ill}
  function automatic logic [17:0] model_out(int ph, logic r, logic z, logic ill);
    logic [3:0] st;
    logic irw, pcw, adr, mw, rw, il;
    logic [1:0] a, b, op, res;
    st = 4'd0; irw = 0; pcw = 0; adr = 0; mw = 0; rw = 0; il = 0;
    a = 2'b00; b = 2'b00; op = 2'b00; res = 2'b00;
    case (ph)
      P_F:   begin st = S_FETCH; irw = r; pcw = r; b = 2'b10; res = 2'b10; end
      P_D:   begin st = S_DECODE; a = 2'b01; b = 2'b01; il = ill; end
      P_MA:  begin st = S_MEMADR; a = 2'b10; b = 2'b01; end
      P_MR:  begin st = S_MEMREAD; adr = 1; end
      P_MW:  begin st = S_MEMWRITE; adr = 1; mw = 1; end
      P_MWB: begin st = S_MEMWB; res = 2'b01; rw = 1; end
      P_ER:  begin st = S_EXECUTER; a = 2'b10; b = 2'b00; op = 2'b10; end
      P_EI:  begin st = S_EXECUTEI; a = 2'b10; b = 2'b01; op = 2'b10; end
      P_AWB: begin st = S_ALUWB; rw = 1; end
      P_J:   begin st = S_JAL; a = 2'b01; b = 2'b10; pcw = 1; end
      P_B:   begin st = S_BEQ; a = 2'b10; b = 2'b00; op = 2'b01; pcw = z; end
      default: ;
    endcase
    return {st, irw, pcw, adr, mw, rw, a, b, op, res, il};
  endfunction

  logic [6:0] ill_ops [4] = '{7'b1111111, 7'b0110111, 7'b0000000, 7'b1100111};

  function automatic logic [6:0] kind_opcode(int k);
    case (k)
      K_LW:  return OP_LOAD;
      K_SW:  return OP_STORE;
      K_R:   return OP_RTYPE;
      K_I:   return OP_ITYPE;
      K_JAL: return OP_JAL;
      K_BEQ: return OP_BRANCH;
      default: return ill_ops[$urandom_range(0, 3)];
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];

  // Per-cycle stimulus built alongside the expectations
  logic [6:0] s_op[$];
  logic       s_rdy[$];
  logic       s_z[$];

  // Append one step; waiting steps get `waits` not-ready cycles before the completing one
  task automatic add_step(int ph, int waits, logic [6:0] op, logic ill, logic waiting);
    logic r, z;
    for (int i = 0; i <= waits; i++) begin
      if (waiting) r = (i == waits);
      else         r = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      s_op.push_back(op);
      s_rdy.push_back(r);
      s_z.push_back(z);
      exp_q.push_back(model_out(ph, r, z, ill));
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(logic [6:0] op, logic r, logic z);
    opcode = op; mem_ready = r; zero = z;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(int k, int fwait, int mwait);
    logic [6:0] op;
    op = kind_opcode(k);
    s_op.delete(); s_rdy.delete(); s_z.delete();
    // opcode is junk during FETCH: the IR is only being loaded there
    add_step(P_F, fwait, 7'($urandom_range(0, 127)), 1'b0, 1'b1);
    add_step(P_D, 0, op, k == K_ILL, 1'b0);
    case (k)
      K_LW:  begin add_step(P_MA, 0, op, 0, 0); add_step(P_MR, mwait, op, 0, 1);
                   add_step(P_MWB, 0, op, 0, 0); end
      K_SW:  begin add_step(P_MA, 0, op, 0, 0); add_step(P_MW, mwait, op, 0, 1); end
      K_R:   begin add_step(P_ER, 0, op, 0, 0); add_step(P_AWB, 0, op, 0, 0); end
      K_I:   begin add_step(P_EI, 0, op, 0, 0); add_step(P_AWB, 0, op, 0, 0); end
      K_JAL: begin add_step(P_J, 0, op, 0, 0); add_step(P_AWB, 0, op, 0, 0); end
      K_BEQ: add_step(P_B, 0, op, 0, 0);
      default: ;
    endcase
    for (int i = 0; i < s_op.size(); i++) drive_cycle(s_op[i], s_rdy[i], s_z[i]);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [17:0] act, e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {state_dbg, ir_write, pc_write, adr_src, mem_write, reg_write,
             alu_src_a, alu_src_b, alu_op, result_src, illegal_instr};
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL trace t=%0t: got st=%0d ir%b pc%b adr%b mw%b rw%b a%b b%b op%b res%b ill%b, required st=%0d ir%b pc%b adr%b mw%b rw%b a%b b%b op%b res%b ill%b",
                 $time, act[17:14], act[13], act[12], act[11], act[10], act[9], act[8:7], act[6:5],
                 act[4:3], act[2:1], act[0], e[17:14], e[13], e[12], e[11], e[10], e[9],
                 e[8:7], e[6:5], e[4:3], e[2:1], e[0]);
      end
    end
  end

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state: FETCH selects, no write enables even with mem_ready=1
    check("rst_state", 8'(state_dbg), 8'(S_FETCH));
    check("rst_ir_write", 8'(ir_write), 8'd0);
    check("rst_pc_write", 8'(pc_write), 8'd0);
    check("rst_selects", {adr_src, 1'b0, alu_src_a, alu_src_b, result_src}, 8'b0000_1010);
    rst = 1'b0;

    // Directed cases
    run_instr(K_LW, 0, 0);
    run_instr(K_SW, 0, 3);
    run_instr(K_BEQ, 0, 0);
    run_instr(K_BEQ, 1, 0);
    run_instr(K_JAL, 0, 0);
    run_instr(K_R, 0, 0);
    run_instr(K_ILL, 0, 0);
    run_instr(K_LW, 2, 2);

    // Random stream
    for (int n = 0; n < 60; n++)
      run_instr($urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 3));

    // Reset pulse in the middle of a waiting MEMWRITE
    drive_cycle(7'h55, 1'b1, 1'b0);
    drive_cycle(OP_STORE, 1'b0, 1'b0);
    drive_cycle(OP_STORE, 1'b0, 1'b0);
    opcode = OP_STORE; mem_ready = 1'b0;
    #1;
    check("pre_rst_state", 8'(state_dbg), 8'(S_MEMWRITE));
    check("pre_rst_mem_write", 8'(mem_write), 8'd1);
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    check("mid_rst_state", 8'(state_dbg), 8'(S_FETCH));
    check("mid_rst_mem_write", 8'(mem_write), 8'd0);
    check("mid_rst_ir_write", 8'(ir_write), 8'd0);
    @(posedge clk);
    #1;
    check("mid_rst_hold_ir", 8'(ir_write), 8'd0);
    check("mid_rst_hold_wen", {5'd0, pc_write, reg_write, mem_write}, 8'd0);
    rst = 1'b0;

    // Instructions after reset start cleanly from FETCH
    run_instr(K_SW, 1, 1);
    run_instr(K_I, 0, 0);

    @(negedge clk);
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
